player_motion_sched: RTL and testbench
======================================

# player_motion_sched

Frame-rate sequencer for the runner's vertical and lateral motion. It accepts single-cycle button pulses from the input debouncer and buffers at most one vertical command and one lane command. On each `frame_tick` it advances the jump arc, slide timer and lane position. Outputs feed the sprite renderer and the collision checker.

## Interface
- `WIDTH`, 12: width of the y coordinate. Screen y decreases upward.
- `GROUND_Y`, 400: resting y.
- `APEX_Y`, 300: highest point of the jump (smallest y).
- `RISE_STEP`, 25: y decrement per tick while rising.
- `FALL_STEP`, 40: y increment per tick while falling.
- `SLIDE_TICKS`, 6: frames spent crouched per slide.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `frame_tick` in 1: one-cycle pulse, once per video frame.
- `btn_jump`, `btn_slide`, `btn_left`, `btn_right` in 1 each: one-cycle command pulses.
- `y_pos` out WIDTH: player y, registered.
- `lane` out 2: 0 = left, 1 = centre, 2 = right. Value 3 is never driven.
- `airborne` out 1: high in RISE or FALL.
- `crouch` out 1: high in SLIDE.
- `landed` out 1: one-cycle pulse on the tick that returns to IDLE from FALL.
- `busy` out 1: state is not IDLE.

## Operation
- Vertical FSM states: IDLE, RISE, FALL, SLIDE.
- Vertical pending slot: 2-bit {NONE, JUMP, SLIDE}.
  - A button pulse writes the slot and overwrites any older entry.
  - `btn_jump` and `btn_slide` in the same cycle store JUMP.
  - The slot is cleared when the FSM consumes it.
  - The slot is also cleared when a command arrives in an illegal context, which is then discarded.
- Lane pending slot: {NONE, LEFT, RIGHT}.
  - `btn_left` and `btn_right` in the same cycle leave the slot unchanged.
  - A newer pulse overwrites the slot.
- FSM updates happen only on `frame_tick`. On each tick:
  - IDLE with slot JUMP: go to RISE and set `y_pos` = GROUND_Y − RISE_STEP.
  - IDLE with slot SLIDE: go to SLIDE and load slide_cnt = SLIDE_TICKS − 1. `y_pos` stays at GROUND_Y.
  - RISE: compute ny = `y_pos` − RISE_STEP, using signed compare with one guard bit.
    - If ny ≤ APEX_Y: `y_pos` = APEX_Y and go to FALL.
    - Otherwise `y_pos` = ny.
  - FALL: compute ny = `y_pos` + FALL_STEP.
    - If ny ≥ GROUND_Y: `y_pos` = GROUND_Y, go to IDLE and pulse `landed`.
    - Otherwise `y_pos` = ny.
  - SLIDE: if slide_cnt = 0, go to IDLE; otherwise decrement slide_cnt.
  - JUMP arriving during RISE or FALL is discarded; no double jump.
  - JUMP arriving during SLIDE is held and consumed on the first tick after returning to IDLE. SLIDE arriving during SLIDE is discarded.
  - SLIDE arriving during FALL is held and consumed after landing. SLIDE arriving during RISE is discarded.
- Lane update on every tick, in any vertical state:
  - LEFT with `lane` > 0: `lane` − 1.
  - RIGHT with `lane` < 2: `lane` + 1.
  - At an edge the move is dropped. The lane slot clears either way.
- A button pulse in the same cycle as `frame_tick` is captured into its slot. It is acted on at the next tick, not the current one.
- Reset, asynchronous and usable at any point, including mid-jump, sets:
  - state IDLE, both slots NONE, slide_cnt 0
  - `y_pos` = GROUND_Y, `lane` = 1
  - `landed`, `airborne`, `crouch`, `busy` all 0

## Timing
- All outputs are registered and change in the cycle after the `frame_tick` edge.
- `airborne`, `crouch` and `busy` are decoded from the registered state.
- Command-to-motion latency is 1 tick if the button pulse precedes the tick by at least 1 cycle.
- Full jump with the default parameters:
  - 4 RISE ticks, ending at y = 300.
  - 3 FALL ticks, with y = 340, 380, then 400 (clamped).
  - Total 7 ticks.
- A slide lasts SLIDE_TICKS ticks in SLIDE.
- `frame_tick` held high for multiple cycles is illegal. Behaviour in that case is a step per cycle, not guarded.

## Structure
- Shared package `motion_pkg` holds:
  - `vstate_t` enum {IDLE, RISE, FALL, SLIDE}
  - `vcmd_t` {NONE, JUMP, SLIDE}
  - `lcmd_t` {NONE, LEFT, RIGHT}
  - lane constants `LANE_L` = 0, `LANE_C` = 1, `LANE_R` = 2
- Sub-module `cmd_slot` is a one-deep, overwrite-on-write, clear-on-consume command register. It is instantiated twice, once for vertical commands and once for lane commands.

## Test plan
- Reset, then `btn_jump`, then 8 ticks → `y_pos` 375, 350, 325, 300, 340, 380, 400, 400. `landed` pulses only on the 7th tick. `airborne` is high for ticks 1–6.
- `btn_jump` at tick 2 of a jump → discarded. The arc is unchanged and no second jump occurs after landing.
- `btn_slide` from IDLE → `crouch` high for exactly 6 ticks. `btn_jump` issued during the slide → RISE begins on the tick after `crouch` falls.
- Reset, then `btn_left` ×2 on separate ticks → `lane` 0, 0. Then `btn_right` ×3 → `lane` 1, 2, 2. `btn_left` and `btn_right` in the same cycle → `lane` unchanged.
- Lane change during a jump → `lane` updates on the same tick as `y_pos`. The arc is unaffected.
- `rst_n` low asynchronously at `y_pos` = 325 in RISE → immediately `y_pos` 400, `lane` 1, all flags 0. A pending JUMP is lost.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared types and constants for the runner motion sequencer.
// Enumerator names carry prefixes because the three enums share one scope.
package motion_pkg;

  typedef enum logic [1:0] {
    VS_IDLE,
    VS_RISE,
    VS_FALL,
    VS_SLIDE
  } vstate_t;

  typedef enum logic [1:0] {
    VC_NONE,
    VC_JUMP,
    VC_SLIDE
  } vcmd_t;

  typedef enum logic [1:0] {
    LC_NONE,
    LC_LEFT,
    LC_RIGHT
  } lcmd_t;

  localparam logic [1:0] LANE_L = 2'd0;
  localparam logic [1:0] LANE_C = 2'd1;
  localparam logic [1:0] LANE_R = 2'd2;

  // A vertical command may wait in the slot only in these state/command
  // pairings; anything else is dropped (no double jump, no stacked slides).
  function automatic logic vcmd_legal(input vstate_t st, input vcmd_t c);
    logic ok;
    case (st)
      VS_IDLE:  ok = 1'b1;
      VS_RISE:  ok = 1'b0;
      VS_FALL:  ok = (c == VC_SLIDE);
      VS_SLIDE: ok = (c == VC_JUMP);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cmd_slot.sv
// One-deep command register: a write overwrites the held entry and beats a
// simultaneous clear, so a pulse coinciding with a consuming tick survives.
module cmd_slot #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] wr_cmd,
  input  logic         clr,
  output logic [W-1:0] cmd
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd <= '0;
    end else if (wr) begin
      cmd <= wr_cmd;
    end else if (clr) begin
      cmd <= '0;
    end
  end

endmodule

// File: rtl/player_motion_sched.sv
// Frame-rate sequencer for the runner: jump arc, slide timer and lane
// position, all advanced on frame_tick from one-deep buffered commands.
module player_motion_sched
  import motion_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int GROUND_Y    = 400,
  parameter int APEX_Y      = 300,
  parameter int RISE_STEP   = 25,
  parameter int FALL_STEP   = 40,
  parameter int SLIDE_TICKS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             btn_jump,
  input  logic             btn_slide,
  input  logic             btn_left,
  input  logic             btn_right,
  output logic [WIDTH-1:0] y_pos,
  output logic [1:0]       lane,
  output logic             airborne,
  output logic             crouch,
  output logic             landed,
  output logic             busy
);

  localparam int CNT_W = (SLIDE_TICKS > 2) ? $clog2(SLIDE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SLIDE_TICKS - 1);

  localparam logic [WIDTH-1:0] GROUND_W = WIDTH'(GROUND_Y);
  localparam logic [WIDTH-1:0] APEX_W   = WIDTH'(APEX_Y);
  localparam logic [WIDTH-1:0] JUMP0_W  = WIDTH'(GROUND_Y - RISE_STEP);

  // One guard bit so a step past zero cannot wrap into a large positive y.
  localparam logic signed [WIDTH:0] RISE_S = (WIDTH+1)'(RISE_STEP);
  localparam logic signed [WIDTH:0] APEX_S = (WIDTH+1)'(APEX_Y);
  localparam logic [WIDTH:0]        FALL_E   = (WIDTH+1)'(FALL_STEP);
  localparam logic [WIDTH:0]        GROUND_E = (WIDTH+1)'(GROUND_Y);

  function automatic logic signed [WIDTH:0] rise_ny(input logic [WIDTH-1:0] y);
    return $signed({1'b0, y}) - RISE_S;
  endfunction

  function automatic logic [WIDTH:0] fall_ny(input logic [WIDTH-1:0] y);
    return {1'b0, y} + FALL_E;
  endfunction

  vstate_t          state;
  logic [CNT_W-1:0] slide_cnt;

  logic [1:0] vslot_q;
  logic [1:0] lslot_q;
  vcmd_t      vslot;
  lcmd_t      lslot;

  logic  v_btn;
  logic  v_wr;
  logic  v_clr;
  vcmd_t v_new;
  logic  l_wr;
  lcmd_t l_new;

  logic signed [WIDTH:0] rn;
  logic [WIDTH:0]        fn;

  assign vslot = vcmd_t'(vslot_q);
  assign lslot = lcmd_t'(lslot_q);

  assign v_btn = btn_jump | btn_slide;
  assign v_new = btn_jump ? VC_JUMP : VC_SLIDE;
  assign v_wr  = v_btn && vcmd_legal(state, v_new);
  // Illegal arrivals wipe the slot; a tick clears whatever IDLE consumes or
  // whatever the new context no longer allows to wait.
  assign v_clr = (v_btn && !v_wr) ||
                 (frame_tick && ((state == VS_IDLE) || !vcmd_legal(state, vslot)));

  assign l_wr  = btn_left ^ btn_right;
  assign l_new = btn_left ? LC_LEFT : LC_RIGHT;

  assign rn = rise_ny(y_pos);
  assign fn = fall_ny(y_pos);

  cmd_slot #(.W(2)) u_vslot (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (v_wr),
    .wr_cmd (v_new),
    .clr    (v_clr),
    .cmd    (vslot_q)
  );

  cmd_slot #(.W(2)) u_lslot (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (l_wr),
    .wr_cmd (l_new),
    .clr    (frame_tick),
    .cmd    (lslot_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= VS_IDLE;
      slide_cnt <= '0;
      y_pos     <= GROUND_W;
      lane      <= LANE_C;
      landed    <= 1'b0;
    end else begin
      landed <= 1'b0;
      if (frame_tick) begin
        case (state)
          VS_IDLE: begin
            if (vslot == VC_JUMP) begin
              state <= VS_RISE;
              y_pos <= JUMP0_W;
            end else if (vslot == VC_SLIDE) begin
              state     <= VS_SLIDE;
              slide_cnt <= CNT_LOAD;
            end
          end
          VS_RISE: begin
            if (rn <= APEX_S) begin
              y_pos <= APEX_W;
              state <= VS_FALL;
            end else begin
              y_pos <= rn[WIDTH-1:0];
            end
          end
          VS_FALL: begin
            if (fn >= GROUND_E) begin
              y_pos  <= GROUND_W;
              state  <= VS_IDLE;
              landed <= 1'b1;
            end else begin
              y_pos <= fn[WIDTH-1:0];
            end
          end
          VS_SLIDE: begin
            if (slide_cnt == '0) begin
              state <= VS_IDLE;
            end else begin
              slide_cnt <= slide_cnt - 1'b1;
            end
          end
          default: state <= VS_IDLE;
        endcase

        // Lane moves are independent of the vertical state; edge moves drop.
        case (lslot)
          LC_LEFT:  if (lane != LANE_L) lane <= lane - 2'd1;
          LC_RIGHT: if (lane != LANE_R) lane <= lane + 2'd1;
          default:  lane <= lane;
        endcase
      end
    end
  end

  assign airborne = (state == VS_RISE) || (state == VS_FALL);
  assign crouch   = (state == VS_SLIDE);
  assign busy     = (state != VS_IDLE);

endmodule

// File: tb/tb_player_motion_sched.sv
// Scoreboard bench for player_motion_sched: stimulus queues the expected
// output snapshot per tick, a monitor pops and compares after each tick.
module tb_player_motion_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        bj = 1'b0, bs = 1'b0, bl = 1'b0, br = 1'b0;
  logic [11:0] y_pos;
  logic [1:0]  lane;
  logic        airborne, crouch, landed, busy;

  always #5 clk = ~clk;

  player_motion_sched #(
    .WIDTH(12), .GROUND_Y(400), .APEX_Y(300),
    .RISE_STEP(25), .FALL_STEP(40), .SLIDE_TICKS(6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_jump   (bj),
    .btn_slide  (bs),
    .btn_left   (bl),
    .btn_right  (br),
    .y_pos      (y_pos),
    .lane       (lane),
    .airborne   (airborne),
    .crouch     (crouch),
    .landed     (landed),
    .busy       (busy)
  );

  typedef struct packed {
    logic [11:0] y;
    logic [1:0]  lane;
    logic        air;
    logic        cr;
    logic        land;
    logic        bsy;
  } snap_t;

  snap_t q[$];
  int    total = 0;
  int    bad = 0;

  function automatic snap_t mk(input int y, input int ln, input bit a, input bit c,
                               input bit l, input bit b);
    snap_t e;
    e.y = y[11:0]; e.lane = ln[1:0]; e.air = a; e.cr = c; e.land = l; e.bsy = b;
    return e;
  endfunction

  function automatic snap_t cur();
    snap_t e;
    e.y = y_pos; e.lane = lane; e.air = airborne; e.cr = crouch; e.land = landed; e.bsy = busy;
    return e;
  endfunction

  task automatic chk(input string nm, input snap_t g, input snap_t w);
    total++;
    if (g !== w) begin
      bad++;
      $display("FAIL %s: got y=%0d lane=%0d air=%0b cr=%0b land=%0b busy=%0b, want y=%0d lane=%0d air=%0b cr=%0b land=%0b busy=%0b",
               nm, g.y, g.lane, g.air, g.cr, g.land, g.bsy, w.y, w.lane, w.air, w.cr, w.land, w.bsy);
    end
  endtask

  // Monitor: every accepted tick produces one output snapshot to check.
  initial begin
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      if (frame_tick && rst_n) begin
        @(negedge clk);
        n++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tick%0d: got an output with no expected entry queued", n);
        end else begin
          snap_t w;
          w = q.pop_front();
          chk($sformatf("tick%0d", n), cur(), w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  task automatic pulse(input bit j, input bit s, input bit l, input bit r);
    @(negedge clk);
    bj = j; bs = s; bl = l; br = r;
    @(negedge clk);
    bj = 1'b0; bs = 1'b0; bl = 1'b0; br = 1'b0;
  endtask

  // One frame tick (optionally with buttons in the same cycle) plus its
  // expected post-tick outputs.
  task automatic tk(input int y, input int ln, input bit a, input bit c,
                    input bit l, input bit b,
                    input bit j = 1'b0, input bit s = 1'b0,
                    input bit lf = 1'b0, input bit rt = 1'b0);
    q.push_back(mk(y, ln, a, c, l, b));
    @(negedge clk);
    frame_tick = 1'b1; bj = j; bs = s; bl = lf; br = rt;
    @(negedge clk);
    frame_tick = 1'b0; bj = 1'b0; bs = 1'b0; bl = 1'b0; br = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", cur(), mk(400, 1, 0, 0, 0, 0));
    rst_n = 1'b1;
    @(negedge clk);

    // Full jump arc.
    pulse(1, 0, 0, 0);
    tk(375, 1, 1, 0, 0, 1);
    tk(350, 1, 1, 0, 0, 1);
    tk(325, 1, 1, 0, 0, 1);
    tk(300, 1, 1, 0, 0, 1);
    tk(340, 1, 1, 0, 0, 1);
    tk(380, 1, 1, 0, 0, 1);
    tk(400, 1, 0, 0, 1, 0);
    tk(400, 1, 0, 0, 0, 0);

    // Second jump pressed mid-rise is dropped.
    pulse(1, 0, 0, 0);
    tk(375, 1, 1, 0, 0, 1);
    tk(350, 1, 1, 0, 0, 1, 1);
    pulse(1, 0, 0, 0);
    tk(325, 1, 1, 0, 0, 1);
    tk(300, 1, 1, 0, 0, 1);
    tk(340, 1, 1, 0, 0, 1);
    tk(380, 1, 1, 0, 0, 1);
    tk(400, 1, 0, 0, 1, 0);
    tk(400, 1, 0, 0, 0, 0);
    tk(400, 1, 0, 0, 0, 0);

    // Slide for six ticks; jump pressed during it starts after it ends.
    pulse(0, 1, 0, 0);
    tk(400, 1, 0, 1, 0, 1);
    pulse(1, 0, 0, 0);
    repeat (5) tk(400, 1, 0, 1, 0, 1);
    tk(400, 1, 0, 0, 0, 0);
    tk(375, 1, 1, 0, 0, 1);
    tk(350, 1, 1, 0, 0, 1);
    tk(325, 1, 1, 0, 0, 1);
    tk(300, 1, 1, 0, 0, 1);
    tk(340, 1, 1, 0, 0, 1);
    tk(380, 1, 1, 0, 0, 1);
    tk(400, 1, 0, 0, 1, 0);

    // Lane moves and edge clamping.
    reset_pulse();
    pulse(0, 0, 1, 0);
    tk(400, 0, 0, 0, 0, 0);
    pulse(0, 0, 1, 0);
    tk(400, 0, 0, 0, 0, 0);
    pulse(0, 0, 0, 1);
    tk(400, 1, 0, 0, 0, 0);
    pulse(0, 0, 0, 1);
    tk(400, 2, 0, 0, 0, 0);
    pulse(0, 0, 0, 1);
    tk(400, 2, 0, 0, 0, 0);
    pulse(0, 0, 1, 1);
    tk(400, 2, 0, 0, 0, 0);
    // Button on the tick cycle takes effect at the following tick.
    tk(400, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    tk(400, 1, 0, 0, 0, 0);
    // Newer lane pulse overwrites the older one.
    pulse(0, 0, 1, 0);
    pulse(0, 0, 0, 1);
    tk(400, 2, 0, 0, 0, 0);

    // Lane changes during a jump; slide pressed in fall waits for landing.
    pulse(1, 0, 1, 0);
    tk(375, 1, 1, 0, 0, 1);
    pulse(0, 0, 0, 1);
    tk(350, 2, 1, 0, 0, 1);
    tk(325, 2, 1, 0, 0, 1);
    tk(300, 2, 1, 0, 0, 1);
    pulse(0, 1, 0, 0);
    tk(340, 2, 1, 0, 0, 1);
    tk(380, 2, 1, 0, 0, 1);
    tk(400, 2, 0, 0, 1, 0);
    repeat (6) tk(400, 2, 0, 1, 0, 1);
    tk(400, 2, 0, 0, 0, 0);

    // Asynchronous reset mid-rise.
    pulse(1, 0, 0, 0);
    tk(375, 2, 1, 0, 0, 1);
    tk(350, 2, 1, 0, 0, 1);
    tk(325, 2, 1, 0, 0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_midjump", cur(), mk(400, 1, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    // Pending jump wiped by reset.
    pulse(1, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tk(400, 1, 0, 0, 0, 0);
    tk(400, 1, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
